// File: rtl/i2s_pkg.sv
// Shared I2S definitions: bit-clock divider math, frame positions, slot naming.
package i2s_pkg;

  typedef enum logic {
    SLOT_LEFT  = 1'b0,
    SLOT_RIGHT = 1'b1
  } slot_e;

  // The left slot always loads at the very first bit clock of a frame
  localparam int LEFT_LOAD_POS = 0;

  // Half-period of the bit clock in system clock cycles
  function automatic int calc_div(input int clk_freq, input int i2s_clk_freq);
    return clk_freq / (2 * i2s_clk_freq);
  endfunction

  // The right slot loads one full slot after the left slot
  function automatic int right_load_pos(input int slot_bits);
    return slot_bits;
  endfunction

  // Word select leads the data by one bit clock (Philips framing)
  function automatic int ws_first_pos(input int slot_bits);
    return slot_bits - 1;
  endfunction

  function automatic int ws_last_pos(input int slot_bits);
    return 2 * slot_bits - 2;
  endfunction

endpackage

// File: rtl/i2s_clk_gen.sv
// Free-running bit-clock generator with one-cycle strobes on the cycle
// whose closing edge produces the SCK rise or fall.
module i2s_clk_gen #(
  parameter int DIV = 16
) (
  input  logic clk,
  input  logic rst,
  output logic i2s_clk,
  output logic rise_stb,
  output logic fall_stb
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          sck_q, sck_d;
  logic          wrap;

  // Divider count and SCK toggle on wrap
  always_comb begin
    wrap  = (cnt_q == CNT_MAX);
    cnt_d = wrap ? '0 : cnt_q + CW'(1);
    sck_d = wrap ? ~sck_q : sck_q;
  end

  // Divider state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      sck_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sck_q <= sck_d;
    end
  end

  assign i2s_clk  = sck_q;
  assign rise_stb = wrap & ~sck_q;
  assign fall_stb = wrap & sck_q;

endmodule

// File: rtl/i2s_tx.sv
// I2S master transmitter: a one-entry hold register feeds a per-slot shift
// register; WS, SD and status pulses change together with the SCK fall.
module i2s_tx
  import i2s_pkg::*;
#(
  parameter int CLK_FREQ     = 50_000_000,
  parameter int I2S_CLK_FREQ = 1_500_000,
  parameter int DATA_SIZE    = 24,
  parameter int SLOT_BITS    = 32,
  parameter int STEREO       = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_SIZE-1:0] sample_data,
  input  logic                 sample_valid,
  output logic                 sample_ready,
  output logic                 i2s_clk,
  output logic                 i2s_ws,
  output logic                 i2s_sd,
  output logic                 underrun,
  output logic                 frame_start
);

  localparam int DIV        = calc_div(CLK_FREQ, I2S_CLK_FREQ);
  localparam int FRAME_BITS = 2 * SLOT_BITS;
  localparam int PW         = $clog2(FRAME_BITS);

  localparam logic [PW-1:0] POS_LAST  = PW'(FRAME_BITS - 1);
  localparam logic [PW-1:0] POS_LEFT  = PW'(LEFT_LOAD_POS);
  localparam logic [PW-1:0] POS_RIGHT = PW'(right_load_pos(SLOT_BITS));
  localparam logic [PW-1:0] WS_FIRST  = PW'(ws_first_pos(SLOT_BITS));
  localparam logic [PW-1:0] WS_LAST   = PW'(ws_last_pos(SLOT_BITS));
  localparam logic [PW-1:0] DATA_LAST = PW'(DATA_SIZE);

  logic fall_stb;
  logic rise_stb_unused;

  logic [PW-1:0]        pos_q, pos_d;
  logic                 hold_full_q, hold_full_d;
  logic [DATA_SIZE-1:0] hold_data_q, hold_data_d;
  logic [DATA_SIZE-1:0] shift_q, shift_d;
  logic [DATA_SIZE-1:0] mono_q, mono_d;
  logic                 ws_q, ws_d;
  logic                 sd_q, sd_d;
  logic                 underrun_q, underrun_d;
  logic                 frame_start_q, frame_start_d;
  logic                 ready_q, ready_d;

  logic                 consume;
  logic                 accept;
  slot_e                cur_slot;
  logic [PW-1:0]        slot_off;
  logic                 in_data;
  logic                 is_load;

  i2s_clk_gen #(
    .DIV(DIV)
  ) u_clk_gen (
    .clk     (clk),
    .rst     (rst),
    .i2s_clk (i2s_clk),
    .rise_stb(rise_stb_unused),
    .fall_stb(fall_stb)
  );

  // Decode where in the frame the upcoming SCK fall sits
  always_comb begin
    cur_slot = (pos_q >= POS_RIGHT) ? SLOT_RIGHT : SLOT_LEFT;
    slot_off = (cur_slot == SLOT_RIGHT) ? pos_q - POS_RIGHT : pos_q;
    in_data  = (slot_off >= PW'(1)) && (slot_off <= DATA_LAST);
    is_load  = (pos_q == POS_LEFT) || ((pos_q == POS_RIGHT) && (STEREO != 0));
  end

  // Frame sequencing: position, word select, slot loads and bit shifting
  always_comb begin
    pos_d         = pos_q;
    ws_d          = ws_q;
    sd_d          = sd_q;
    shift_d       = shift_q;
    mono_d        = mono_q;
    underrun_d    = 1'b0;
    frame_start_d = 1'b0;
    consume       = 1'b0;
    if (fall_stb) begin
      pos_d         = (pos_q == POS_LAST) ? '0 : pos_q + PW'(1);
      frame_start_d = (pos_q == POS_LEFT);
      ws_d          = (pos_q >= WS_FIRST) && (pos_q <= WS_LAST);
      sd_d          = 1'b0;
      if (is_load) begin
        consume    = hold_full_q;
        underrun_d = ~hold_full_q;
        shift_d    = hold_full_q ? hold_data_q : '0;
        if (pos_q == POS_LEFT) begin
          mono_d = hold_full_q ? hold_data_q : '0;
        end
      end else if (pos_q == POS_RIGHT) begin
        shift_d = mono_q;
      end else if (in_data) begin
        sd_d    = shift_q[DATA_SIZE-1];
        shift_d = shift_q << 1;
      end
    end
  end

  // Stream side: slot loads see only the pre-edge hold state
  always_comb begin
    accept      = sample_valid & ready_q;
    hold_full_d = (hold_full_q & ~consume) | accept;
    hold_data_d = accept ? sample_data : hold_data_q;
    ready_d     = ~hold_full_d;
  end

  // State registers; reset aborts any frame in progress
  always_ff @(posedge clk) begin
    if (rst) begin
      pos_q         <= '0;
      hold_full_q   <= 1'b0;
      hold_data_q   <= '0;
      shift_q       <= '0;
      mono_q        <= '0;
      ws_q          <= 1'b0;
      sd_q          <= 1'b0;
      underrun_q    <= 1'b0;
      frame_start_q <= 1'b0;
      ready_q       <= 1'b0;
    end else begin
      pos_q         <= pos_d;
      hold_full_q   <= hold_full_d;
      hold_data_q   <= hold_data_d;
      shift_q       <= shift_d;
      mono_q        <= mono_d;
      ws_q          <= ws_d;
      sd_q          <= sd_d;
      underrun_q    <= underrun_d;
      frame_start_q <= frame_start_d;
      ready_q       <= ready_d;
    end
  end

  assign sample_ready = ready_q;
  assign i2s_ws       = ws_q;
  assign i2s_sd       = sd_q;
  assign underrun     = underrun_q;
  assign frame_start  = frame_start_q;

endmodule

// File: tb/tb_i2s_tx.sv
// Self-checking bench for i2s_tx: a stereo and a mono instance run side by
// side against a time-based reference model plus directed corner sequences.
module tb_i2s_tx;

  localparam int DIV   = 4;
  localparam int SLOT  = 32;
  localparam int DW    = 24;
  localparam int FRAME = 2 * SLOT;
  localparam int FPER  = 2 * DIV;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    valid;
  logic [DW-1:0] data0, data1;

  wire ready_0, sck_0, ws_0, sd_0, ur_0, fs_0;
  wire ready_1, sck_1, ws_1, sd_1, ur_1, fs_1;

  wire [1:0] dut_ready = {ready_1, ready_0};
  wire [1:0] dut_sck   = {sck_1, sck_0};
  wire [1:0] dut_ws    = {ws_1, ws_0};
  wire [1:0] dut_sd    = {sd_1, sd_0};
  wire [1:0] dut_ur    = {ur_1, ur_0};
  wire [1:0] dut_fs    = {fs_1, fs_0};

  i2s_tx #(
    .CLK_FREQ(8), .I2S_CLK_FREQ(1), .DATA_SIZE(DW), .SLOT_BITS(SLOT), .STEREO(1)
  ) dut_stereo (
    .clk(clk), .rst(rst), .sample_data(data0), .sample_valid(valid[0]),
    .sample_ready(ready_0), .i2s_clk(sck_0), .i2s_ws(ws_0), .i2s_sd(sd_0),
    .underrun(ur_0), .frame_start(fs_0)
  );

  i2s_tx #(
    .CLK_FREQ(8), .I2S_CLK_FREQ(1), .DATA_SIZE(DW), .SLOT_BITS(SLOT), .STEREO(0)
  ) dut_mono (
    .clk(clk), .rst(rst), .sample_data(data1), .sample_valid(valid[1]),
    .sample_ready(ready_1), .i2s_clk(sck_1), .i2s_ws(ws_1), .i2s_sd(sd_1),
    .underrun(ur_1), .frame_start(fs_1)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model state: time since reset, hold register, per-slot samples
  int            m_t;
  bit            m_fall;
  int            m_p;
  bit            m_hold_full [2];
  logic [DW-1:0] m_hold_data [2];
  logic [DW-1:0] m_left [2];
  logic [DW-1:0] m_right [2];
  bit e_clk;
  bit e_ready [2];
  bit e_ws [2];
  bit e_sd [2];
  bit e_ur [2];
  bit e_fs [2];

  // Observations collected from the DUTs
  logic [1:0]    prev_ready;
  logic [1:0]    dut_acc;
  int            ur_cnt [2];
  int            acc_cnt [2];
  logic [DW-1:0] cap_left [2];
  logic [DW-1:0] cap_right [2];

  typedef struct {
    int t;
    bit valid_in;
    bit clk_v;
    bit ready_v;
    bit ws_v;
    bit ur_v;
    bit fs_v;
    bit ur_mono_v;
  } vec_t;

  vec_t vecs [$];

  task automatic checkOutput(input string name, input int inst, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s[%0d] t=%0d: got %b, expected %b", name, inst, m_t, act, exp);
    end
  endtask

  task automatic checkValue(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s t=%0d: got %0h, expected %0h", name, m_t, act, exp);
    end
  endtask

  // Advance the model one clk edge using the inputs present before the edge
  task automatic model_step();
    logic [DW-1:0] in_data [2];
    in_data[0] = data0;
    in_data[1] = data1;
    m_fall = 1'b0;
    m_p    = -1;
    if (rst) begin
      m_t   = 0;
      e_clk = 1'b0;
      for (int i = 0; i < 2; i++) begin
        m_hold_full[i] = 1'b0;
        m_hold_data[i] = '0;
        m_left[i]      = '0;
        m_right[i]     = '0;
        e_ready[i]     = 1'b0;
        e_ws[i]        = 1'b0;
        e_sd[i]        = 1'b0;
        e_ur[i]        = 1'b0;
        e_fs[i]        = 1'b0;
      end
    end else begin
      m_t++;
      e_clk = ((m_t / DIV) % 2) == 1;
      if ((m_t % FPER) == 0) begin
        m_fall = 1'b1;
        m_p    = (m_t / FPER - 1) % FRAME;
      end
      for (int i = 0; i < 2; i++) begin
        bit consume;
        bit acc;
        consume = 1'b0;
        acc     = valid[i] && e_ready[i];
        e_ur[i] = 1'b0;
        e_fs[i] = 1'b0;
        if (m_fall) begin
          e_fs[i] = (m_p == 0);
          e_ws[i] = (m_p >= SLOT - 1) && (m_p <= 2 * SLOT - 2);
          if (m_p == 0) begin
            m_left[i] = m_hold_full[i] ? m_hold_data[i] : '0;
            e_ur[i]   = !m_hold_full[i];
            consume   = m_hold_full[i];
          end else if (m_p == SLOT) begin
            if (i == 0) begin
              m_right[i] = m_hold_full[i] ? m_hold_data[i] : '0;
              e_ur[i]    = !m_hold_full[i];
              consume    = m_hold_full[i];
            end else begin
              m_right[i] = m_left[i];
            end
          end
          if (m_p >= 1 && m_p <= DW)
            e_sd[i] = m_left[i][DW - m_p];
          else if (m_p >= SLOT + 1 && m_p <= SLOT + DW)
            e_sd[i] = m_right[i][DW - (m_p - SLOT)];
          else
            e_sd[i] = 1'b0;
        end
        if (consume) m_hold_full[i] = 1'b0;
        if (acc) begin
          m_hold_full[i] = 1'b1;
          m_hold_data[i] = in_data[i];
        end
        e_ready[i] = !m_hold_full[i];
      end
    end
  endtask

  // One clk cycle: model update on the edge, compare 1 time unit later
  task automatic tick();
    prev_ready = dut_ready;
    @(posedge clk);
    dut_acc = prev_ready & valid;
    model_step();
    #1;
    for (int i = 0; i < 2; i++) begin
      checkOutput("sck", i, dut_sck[i], e_clk);
      checkOutput("sample_ready", i, dut_ready[i], e_ready[i]);
      checkOutput("ws", i, dut_ws[i], e_ws[i]);
      checkOutput("sd", i, dut_sd[i], e_sd[i]);
      checkOutput("underrun", i, dut_ur[i], e_ur[i]);
      checkOutput("frame_start", i, dut_fs[i], e_fs[i]);
      ur_cnt[i]  += int'(dut_ur[i]);
      acc_cnt[i] += int'(dut_acc[i]);
      if (m_fall && m_p >= 1 && m_p <= DW)
        cap_left[i][DW - m_p] = dut_sd[i];
      if (m_fall && m_p >= SLOT + 1 && m_p <= SLOT + DW)
        cap_right[i][DW - (m_p - SLOT)] = dut_sd[i];
    end
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    valid = 2'b00;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      ur_cnt[i]  = 0;
      acc_cnt[i] = 0;
    end
  endtask

  task automatic run_to(input int t);
    while (m_t < t) tick();
  endtask

  // Offer one sample and hold valid until the DUT takes it
  task automatic applyStimulus(input int inst, input logic [DW-1:0] d);
    bit done;
    done = 1'b0;
    if (inst == 0) data0 = d; else data1 = d;
    valid[inst] = 1'b1;
    for (int n = 0; n < 2000 && !done; n++) begin
      done = dut_ready[inst];
      tick();
    end
    valid[inst] = 1'b0;
    checkOutput("push_accept", inst, done, 1'b1);
  endtask

  initial begin
    // Idle reference timing, hand-derived for DIV=4, SLOT_BITS=32
    vecs.push_back('{1,   0, 0, 1, 0, 0, 0, 0});
    vecs.push_back('{3,   0, 0, 1, 0, 0, 0, 0});
    vecs.push_back('{4,   0, 1, 1, 0, 0, 0, 0});
    vecs.push_back('{7,   0, 1, 1, 0, 0, 0, 0});
    vecs.push_back('{8,   0, 0, 1, 0, 1, 1, 1});
    vecs.push_back('{9,   0, 0, 1, 0, 0, 0, 0});
    vecs.push_back('{12,  0, 1, 1, 0, 0, 0, 0});
    vecs.push_back('{16,  0, 0, 1, 0, 0, 0, 0});
    vecs.push_back('{248, 0, 0, 1, 0, 0, 0, 0});
    vecs.push_back('{256, 0, 0, 1, 1, 0, 0, 0});
    vecs.push_back('{264, 0, 0, 1, 1, 1, 0, 0});
    vecs.push_back('{265, 0, 0, 1, 1, 0, 0, 0});
    vecs.push_back('{504, 0, 0, 1, 1, 0, 0, 0});
    vecs.push_back('{512, 0, 0, 1, 0, 0, 0, 0});
    vecs.push_back('{520, 0, 0, 1, 0, 1, 1, 1});

    rst   = 1'b1;
    valid = 2'b00;
    data0 = '0;
    data1 = '0;
    m_t   = 0;
    repeat (2) @(negedge clk);

    // Reset state and idle timing from the vector table
    $display("[TB] idle timing after reset");
    do_reset();
    checkOutput("rst_ready", 0, dut_ready[0], 1'b0);
    checkOutput("rst_sck", 0, dut_sck[0], 1'b0);
    checkOutput("rst_sd", 0, dut_sd[0], 1'b0);
    for (int k = 0; k < vecs.size(); k++) begin
      while (m_t < vecs[k].t) begin
        valid[0] = vecs[k].valid_in;
        tick();
      end
      checkOutput("vec_sck", k, dut_sck[0], vecs[k].clk_v);
      checkOutput("vec_ready", k, dut_ready[0], vecs[k].ready_v);
      checkOutput("vec_ws", k, dut_ws[0], vecs[k].ws_v);
      checkOutput("vec_underrun", k, dut_ur[0], vecs[k].ur_v);
      checkOutput("vec_frame_start", k, dut_fs[0], vecs[k].fs_v);
      checkOutput("vec_underrun_mono", k, dut_ur[1], vecs[k].ur_mono_v);
      checkOutput("vec_sd", k, dut_sd[0], 1'b0);
    end

    // Left then right sample in one frame
    $display("[TB] directed left/right frame");
    do_reset();
    applyStimulus(0, 24'hA50F3C);
    applyStimulus(0, 24'h800001);
    run_to(519);
    checkValue("lr_underruns", ur_cnt[0], 0);
    checkValue("lr_left_word", int'(cap_left[0]), int'(24'hA50F3C));
    checkValue("lr_right_word", int'(cap_right[0]), int'(24'h800001));

    // Sample offered exactly on the right-slot load edge
    $display("[TB] late sample at right load");
    do_reset();
    run_to(263);
    data0    = 24'h6BD1E7;
    valid[0] = 1'b1;
    tick();
    valid[0] = 1'b0;
    checkOutput("late_underrun", 0, dut_ur[0], 1'b1);
    checkOutput("late_ready", 0, dut_ready[0], 1'b0);
    run_to(720);
    checkValue("late_next_left", int'(cap_left[0]), int'(24'h6BD1E7));

    // Continuous valid on both instances; mono always sends 123456
    $display("[TB] continuous streaming");
    do_reset();
    valid = 2'b11;
    data0 = DW'($urandom);
    data1 = 24'h123456;
    while (m_t < 1544) begin
      tick();
      if (dut_acc[0]) data0 = DW'($urandom);
      if (m_t == 520) begin
        for (int i = 0; i < 2; i++) begin
          ur_cnt[i]  = 0;
          acc_cnt[i] = 0;
        end
      end
    end
    valid = 2'b00;
    checkValue("cont_stereo_accepts", acc_cnt[0], 4);
    checkValue("cont_mono_accepts", acc_cnt[1], 2);
    checkValue("cont_stereo_underruns", ur_cnt[0], 0);
    checkValue("cont_mono_underruns", ur_cnt[1], 0);
    checkValue("mono_left_word", int'(cap_left[1]), int'(24'h123456));
    checkValue("mono_right_word", int'(cap_right[1]), int'(24'h123456));

    // Sparse random traffic against the model
    $display("[TB] random traffic");
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      valid[0] = ($urandom_range(0, 99) < 3);
      valid[1] = ($urandom_range(0, 99) < 2);
      data0    = DW'($urandom);
      data1    = DW'($urandom);
      tick();
    end
    valid = 2'b00;

    // Reset in the middle of the right slot with a sample held
    $display("[TB] mid-frame reset");
    do_reset();
    applyStimulus(0, 24'h111111);
    applyStimulus(0, 24'h222222);
    applyStimulus(0, 24'h333333);
    run_to(330);
    checkOutput("pre_rst_held", 0, dut_ready[0], 1'b0);
    do_reset();
    checkOutput("mid_rst_sck", 0, dut_sck[0], 1'b0);
    checkOutput("mid_rst_ws", 0, dut_ws[0], 1'b0);
    checkOutput("mid_rst_sd", 0, dut_sd[0], 1'b0);
    checkOutput("mid_rst_ready", 0, dut_ready[0], 1'b0);
    run_to(8);
    checkOutput("restart_frame_start", 0, dut_fs[0], 1'b1);
    checkOutput("restart_discard_underrun", 0, dut_ur[0], 1'b1);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/i2s_tx.md
Name: i2s_tx

Overview:
I2S master transmitter, the playback counterpart of the microphone capture path. It generates the bit clock and word select, then serialises PCM samples to an external DAC/amplifier. Samples arrive on a valid/ready stream, normally fed from the same SPI-loaded FIFO infrastructure. A one-entry holding register decouples the stream from slot timing; missing data is replaced by silence and flagged.

Parameters:
CLK_FREQ, 50_000_000, system clock frequency in Hz
I2S_CLK_FREQ, 1_500_000, target bit-clock frequency in Hz; half-period DIV = CLK_FREQ/(2*I2S_CLK_FREQ) (integer division, must be >=1; default gives DIV = 16)
DATA_SIZE, 24, sample width in bits; must be <= SLOT_BITS-1
SLOT_BITS, 32, bit clocks per channel slot; a frame is 2*SLOT_BITS bit clocks
STEREO, 0, 0: one sample per frame, sent in both slots; 1: two samples per frame, left then right

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
sample_data  in  DATA_SIZE  two's-complement PCM sample
sample_valid  in  1  sample_data is valid
sample_ready  out  1  holding register empty; a transfer occurs when valid&ready at a clk edge
i2s_clk  out  1  bit clock (SCK)
i2s_ws  out  1  word select: 0 = left, 1 = right
i2s_sd  out  1  serial data, MSB first
underrun  out  1  one-cycle pulse when a slot loads with no sample held
frame_start  out  1  one-cycle pulse on the falling-edge strobe at frame position p = 0

Behaviour:
- Reset (rst=1 at a clk edge): i2s_clk=0, i2s_ws=0, i2s_sd=0, sample_ready=0, underrun=0, frame_start=0. Divider, position and shift registers clear; hold register empties. Reset mid-frame aborts the frame immediately, with no flush.
- The cycle after reset deasserts: sample_ready=1.
- Clock generation: the divider counts 0..DIV-1 and i2s_clk toggles when the count wraps.
  - The first rising edge occurs DIV cycles after reset release.
  - The first falling edge occurs 2*DIV cycles after reset release.
  - fall_stb is asserted in the same clk cycle in which i2s_clk goes 1->0.
- Frame position p (0..2*SLOT_BITS-1) advances on each fall_stb and wraps to 0. The first fall_stb after reset is p=0. All of ws, sd, underrun and frame_start update only on fall_stb, so they are stable at the following SCK rising edge.
- Word select (Philips I2S, one-bit lead): i2s_ws=1 for p in [SLOT_BITS-1, 2*SLOT_BITS-2], otherwise 0.
- Slot load at p=0 (left) and p=SLOT_BITS (right):
  - If the hold register is full, its sample moves to the shift register and the hold register empties.
  - If it is empty, the shift register loads zero and underrun pulses.
  - With STEREO=0, the right slot reuses the left sample without consuming or flagging; only p=0 loads.
- Data:
  - i2s_sd carries the shift-register MSB at p = 1..DATA_SIZE (left slot) and p = SLOT_BITS+1..SLOT_BITS+DATA_SIZE (right slot).
  - i2s_sd=0 at all other positions, including p=0 and p=SLOT_BITS.
  - The shift register shifts left on each data-bit fall_stb.
- Handshake:
  - sample_ready = ~hold_full (registered state, no combinational path from sample_valid).
  - An accept and a slot load in the same cycle: the load sees only the pre-edge hold state. If the hold was empty, the slot underruns and the accepted sample waits for the next slot. If the hold was full, it is handed over and the new sample may not be accepted that cycle (ready was 0).
- No backpressure to the bit clock: SCK and WS run continuously after reset regardless of data.

Decomposition:
- Package i2s_pkg: the DIV computation function, frame-position constants (left/right load positions, WS window bounds), and a slot enum {SLOT_LEFT, SLOT_RIGHT}. The capture block shares this package.
- Sub-module i2s_clk_gen (parameter DIV; outputs i2s_clk, rise_stb, fall_stb). It is reusable by the receiver.

Test Plan:
All scenarios use CLK_FREQ=8, I2S_CLK_FREQ=1 (DIV=4), SLOT_BITS=32, DATA_SIZE=24, STEREO=1 unless stated.
- Reset release with no stimulus -> first i2s_clk rise at cycle 4, first fall at cycle 8 with frame_start=1; SCK period 8 cycles; ws low for 31 bit clocks then high for 32; sd constantly 0; underrun pulses at p=0 and p=32 of every frame.
- Push L=24'hA5_0F_3C, then R=24'h80_0001 -> sd at p=1..24 is A50F3C MSB first, p=25..32 zero, p=33..56 is 800001; ws rises at p=31 and falls at p=63; no underrun.
- Hold sample_valid=1 continuously -> sample_ready alternates, exactly one accept per slot; no underrun after the first frame; the sample order on sd matches the push order.
- Present a sample only in the exact cycle of the p=32 load strobe with the hold empty -> underrun pulses for the right slot (zeros sent); the sample appears in the next left slot.
- STEREO=0, push 24'h123456 per frame -> both slots carry 123456; one accept per frame; underrun never pulses at p=32.
- Assert rst for 1 cycle at p=40 mid-slot -> all outputs 0 the next cycle; the frame restarts with the fall at 8 cycles and frame_start=1; the held sample is discarded.
